// File: rtl/ser_load_ctrl.sv
// ser_load_ctrl: round-robin arbiter and MSB-first serial loader for the serial-in shift register.
// Optional even-parity trailer bit is compiled in with `define SER_PARITY_EN.
module ser_load_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sd_out,
  output logic             sh_en,
  output logic             latch,
  output logic             busy,
  output logic             grant_id,
  output logic [1:0]       dbg_state
);

`ifdef SER_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_word, w_word_nxt;
  logic             r_last, r_grant;
  logic             r_sh_en, r_sd_out, r_latch, r_busy;
  logic             w_gnt0, w_gnt1, w_accept, w_bit_nxt;

  // Handshake: a word transfers on a cycle where valid and ready are both high.
  // Ready is offered only in IDLE, to at most one requester, and never while rst is high.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (r_state == S_IDLE && !rst) begin
      w_gnt0 = req0_valid && (!req1_valid || r_last);
      w_gnt1 = req1_valid && (!req0_valid || !r_last);
    end
    w_accept = w_gnt0 || w_gnt1;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_word_nxt  = w_gnt1 ? req1_data : req0_data;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(N - 1)) begin
          w_state_nxt = S_LATCH;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_LATCH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bit to present next cycle; the outputs are registered from the next-state values.
  always_comb begin
    w_bit_nxt = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_cnt_nxt == CW'(WIDTH - 1 - i)) w_bit_nxt = w_word_nxt[i];
    end
`ifdef SER_PARITY_EN
    if (w_cnt_nxt == CW'(WIDTH)) w_bit_nxt = ^w_word_nxt;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_word   <= '0;
      r_last   <= 1'b1;
      r_grant  <= 1'b0;
      r_sh_en  <= 1'b0;
      r_sd_out <= 1'b0;
      r_latch  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_word   <= w_word_nxt;
      if (w_accept) begin
        r_last  <= w_gnt1;
        r_grant <= w_gnt1;
      end
      r_sh_en  <= (w_state_nxt == S_SHIFT);
      r_sd_out <= (w_state_nxt == S_SHIFT) && w_bit_nxt;
      r_latch  <= (w_state_nxt == S_LATCH);
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign sh_en     = r_sh_en;
  assign sd_out    = r_sd_out;
  assign latch     = r_latch;
  assign busy      = r_busy;
  assign grant_id  = r_grant;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ser_load_ctrl.sv
// Bench for ser_load_ctrl: per-transfer expected-waveform queue model, a model shift register,
// directed scenarios pinned by literals, then randomized traffic with occasional resets.
module tb_ser_load_ctrl;
  localparam int W = 4;
`ifdef SER_PARITY_EN
  localparam int N = W + 1;
  localparam logic [W-1:0] D_SINGLE   = 4'b1011;
  localparam logic [N-1:0] EXP_SINGLE = 5'b10111;
  localparam logic [N-1:0] EXP_STAB   = 5'b10010;
`else
  localparam int N = W;
  localparam logic [W-1:0] D_SINGLE   = 4'b1010;
  localparam logic [N-1:0] EXP_SINGLE = 4'b1010;
  localparam logic [N-1:0] EXP_STAB   = 4'b1001;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_data = '0, req1_data = '0;
  logic         req0_ready, req1_ready, sd_out, sh_en, latch, busy, grant_id;
  logic [1:0]   dbg_state;

  ser_load_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .sd_out(sd_out), .sh_en(sh_en), .latch(latch), .busy(busy),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  // downstream serial-in register
  logic [N-1:0] q_reg;
  always @(posedge clk or posedge rst) begin
    if (rst) q_reg <= '0;
    else if (sh_en) q_reg <= {q_reg[N-2:0], sd_out};
  end

  // scoreboard: one entry per cycle of a transfer {busy, grant, latch, sh_en, sd_out}
  logic [4:0]   exp_q[$];
  logic [N-1:0] word_q[$];
  logic         m_last = 1'b1, m_grant = 1'b0;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, acc_cyc = 0, prev_latch = 0, lat = 0, gap = 0, n_latch = 0, l0 = 0;
  logic [15:0] sd_log = '0;
  logic [7:0]  grant_log = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver + per-cycle compare + model update
  task automatic step(input logic r, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1);
    logic [4:0]   cur;
    logic         idle, e0, e1, b;
    logic [W-1:0] w;
    logic [N-1:0] qx;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    if (r) begin
      exp_q.delete(); word_q.delete();
      m_last = 1'b1; m_grant = 1'b0;
    end
    idle = (exp_q.size() == 0) && !r;
    cur  = (exp_q.size() > 0) ? exp_q[0] : {1'b0, m_grant, 3'b000};
    e0   = idle && v0 && (!v1 || m_last);
    e1   = idle && v1 && (!v0 || !m_last);
    chk("req0_ready", req0_ready, e0);
    chk("req1_ready", req1_ready, e1);
    chk("busy", busy, cur[4]);
    chk("grant_id", grant_id, cur[3]);
    chk("latch", latch, cur[2]);
    chk("sh_en", sh_en, cur[1]);
    chk("sd_out", sd_out, cur[0]);
    if (cur[2] && word_q.size() > 0) chk("q_at_latch", q_reg, word_q.pop_front());
    if (sh_en === 1'b1) sd_log = {sd_log[14:0], sd_out};
    if (latch === 1'b1) begin
      n_latch++;
      grant_log  = {grant_log[6:0], grant_id};
      lat        = cyc - acc_cyc;
      gap        = cyc - prev_latch;
      prev_latch = cyc;
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (e0 || e1) begin
      w = e1 ? d1 : d0;
      m_grant = e1;
      m_last  = e1;
      acc_cyc = cyc;
      for (int k = 0; k < N; k++) begin
        if (k < W) b = w[W-1-k];
        else       b = ^w;
        exp_q.push_back({1'b1, e1, 1'b0, 1'b1, b});
      end
      exp_q.push_back({1'b1, e1, 1'b1, 1'b0, 1'b0});
`ifdef SER_PARITY_EN
      qx = {w, ^w};
`else
      qx = w;
`endif
      word_q.push_back(qx);
    end
    cyc++;
  endtask

  initial begin
    // reset held with both requesters valid
    step(1'b1, 1'b1, 4'hF, 1'b1, 4'hF);
    step(1'b1, 1'b1, 4'hF, 1'b1, 4'hF);

    // single word from req0 (tie goes to req0 after reset)
    sd_log = '0;
    step(1'b0, 1'b1, D_SINGLE, 1'b1, 4'h5);
    chk("post_reset_ready0", req0_ready, 1'b1);
    chk("post_reset_ready1", req1_ready, 1'b0);
    repeat (N + 2) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("single_bits", sd_log[N-1:0], EXP_SINGLE);
    chk("single_latency", lat, N + 1);
    chk("single_grant", grant_log[0], 1'b0);
    chk("single_latch_count", n_latch, 1);

    // round-robin with both valid continuously
    step(1'b1, 1'b0, '0, 1'b0, '0);
    grant_log = '0;
    repeat (4 * (N + 2)) step(1'b0, 1'b1, 4'hC, 1'b1, 4'h3);
    chk("rr_grants", grant_log[3:0], 4'b0101);
    chk("rr_spacing", gap, N + 2);

    // reset after the second shift aborts the transfer
    l0 = n_latch;
    step(1'b0, 1'b1, 4'hB, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    chk("abort_sh_en", sh_en, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_latch", latch, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    repeat (N + 2) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("abort_no_latch", n_latch, l0);
    step(1'b0, 1'b0, '0, 1'b1, 4'h6);
    repeat (N + 2) step(1'b0, 1'b0, '0, 1'b0, '0);
    chk("after_abort_latch", n_latch, l0 + 1);

    // input data changes after accept are ignored
    sd_log = '0;
    step(1'b0, 1'b1, 4'h9, 1'b0, '0);
    repeat (N + 2) step(1'b0, 1'b0, 4'h6, 1'b0, '0);
    chk("stable_bits", sd_log[N-1:0], EXP_STAB);

    // randomized traffic with occasional reset
    repeat (500) begin
      step(1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), W'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
